// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, owner index and lock indication,
// with burst/lock tracking so ownership never moves mid-burst or mid-lock.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MASTER_W       = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
  localparam logic [MASTER_W-1:0]    DEF_PTR   = MASTER_W'((DEFAULT_MASTER + 1) % NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0]    master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [3:0]             beats_q, beats_d;
  logic [MASTER_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                   owner_lock_s;
  logic                   hold_s;
  logic [NUM_MASTERS-1:0] req_rot_s;
  logic                   found_s;
  logic [MASTER_W-1:0]    winner_s;
  logic [MASTER_W-1:0]    grant_idx_s;
  logic                   grant_lock_s;

  // Remaining SEQ beats after a NONSEQ of the given fixed-length burst type.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    logic [3:0] n;
    case (burst)
      3'b010, 3'b011: n = 4'd3;
      3'b100, 3'b101: n = 4'd7;
      3'b110, 3'b111: n = 4'd15;
      default:        n = 4'd0;
    endcase
    return n;
  endfunction

  // Beat counter; a non-OKAY first response cycle aborts the burst.
  always_comb begin
    beats_d = beats_q;
    if (!HREADY && (HRESP != RESP_OKAY)) begin
      beats_d = 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: beats_d = burst_beats(HBURST);
        TRANS_SEQ:    beats_d = (beats_q != 4'd0) ? (beats_q - 4'd1) : beats_q;
        default:      beats_d = beats_q;
      endcase
    end else begin
      beats_d = beats_q;
    end
  end

  // Hold condition: burst in flight or current owner keeping a locked request.
  always_comb begin
    owner_lock_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (master_q == MASTER_W'(i)) begin
        owner_lock_s = HLOCK[i] & HBUSREQ[i];
      end else begin
        owner_lock_s = owner_lock_s;
      end
    end
    hold_s = (beats_d != 4'd0) || owner_lock_s;
  end

  // Round-robin search: rotate requests so bit 0 is the rr_ptr position.
  always_comb begin
    int idx;
    req_rot_s = NUM_MASTERS'({HBUSREQ, HBUSREQ} >> rr_ptr_q);
    found_s   = 1'b0;
    winner_s  = DEF_IDX;
    idx       = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found_s && req_rot_s[i]) begin
        found_s = 1'b1;
        idx     = int'(rr_ptr_q) + i;
        if (idx >= NUM_MASTERS) begin
          idx = idx - NUM_MASTERS;
        end else begin
          idx = idx;
        end
        winner_s = MASTER_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant and pointer update.
  always_comb begin
    int nxt;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    nxt      = int'(winner_s) + 1;
    if (nxt >= NUM_MASTERS) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    if (!hold_s) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_d[i] = (winner_s == MASTER_W'(i));
      end
      if (found_s) begin
        rr_ptr_d = MASTER_W'(nxt);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Ownership follows the registered grant, but only when the data phase completes.
  always_comb begin
    grant_idx_s  = DEF_IDX;
    grant_lock_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        grant_idx_s  = MASTER_W'(i);
        grant_lock_s = HLOCK[i];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
    if (HREADY) begin
      master_d   = grant_idx_s;
      mastlock_d = grant_lock_s;
    end else begin
      master_d   = master_q;
      mastlock_d = mastlock_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      beats_q    <= 4'd0;
      rr_ptr_q   <= DEF_PTR;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      beats_q    <= beats_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule
